// File: rtl/ahb_pkg.sv
// Shared AHB definitions: htrans encodings and the arbiter state enum.
// The LOCKED state exists only when AHB_ARB_LOCK_EN is defined.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1
`ifdef AHB_ARB_LOCK_EN
        ,
        ARB_LOCKED = 2'd2
`endif
    } arb_state_e;

    // A beat is any transfer that moves data (NONSEQ or SEQ).
    function automatic logic is_beat(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority search: scans from (last+1) mod N upward and returns
// the first requester as a one-hot vector and as an index.
module ahb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic [N-1:0] gnt,
    output logic [1:0]   idx
);

    always_comb begin
        int   pos;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = 2'(pos);
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with per-grant beat quota.
// Define AHB_ARB_LOCK_EN to add the hlock port and the LOCKED state.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int QUOTA          = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0] hlock,
`endif
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic                   hmastlock
);

    localparam logic [1:0]             DEF_IDX = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             QUOTA_L = 8'(QUOTA);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             last_q, last_d;
    logic [7:0]             beat_q, beat_d;
    logic [1:0]             hmaster_q, hmaster_d;

    logic [7:0]             beat_inc;
    logic                   owner_req;
    logic [NUM_MASTERS-1:0] others;
    logic                   rearb;
    logic                   take;
    logic [NUM_MASTERS-1:0] pick_req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [1:0]             pick_idx;

    assign owner_req = |(hbusreq & grant_q);
    assign others    = hbusreq & ~grant_q;
    assign beat_inc  = (is_beat(htrans) && beat_q != QUOTA_L) ? beat_q + 8'd1 : beat_q;
    assign rearb     = !owner_req || ((beat_inc == QUOTA_L) && |others);
    // In IDLE the parked default master competes normally; otherwise the owner is excluded.
    assign pick_req  = (state_q == ARB_IDLE) ? hbusreq : others;

    ahb_rr_pick #(
        .N    (NUM_MASTERS)
    ) u_pick (
        .req  (pick_req),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

`ifdef AHB_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic owner_lock;
    assign owner_lock = |(hlock & grant_q);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        beat_d    = beat_q;
        hmaster_d = hmaster_q;
        take      = 1'b0;
`ifdef AHB_ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        if (hready) begin
            hmaster_d = owner_q;
            beat_d    = beat_inc;
            case (state_q)
                ARB_IDLE: begin
                    beat_d = '0;
                    take   = |hbusreq;
                end
                ARB_ACTIVE: begin
`ifdef AHB_ARB_LOCK_EN
                    if (owner_req && owner_lock) begin
                        state_d = ARB_LOCKED;
                        lock_d  = 1'b1;
                    end else begin
                        take = rearb;
                    end
`else
                    take = rearb;
`endif
                end
`ifdef AHB_ARB_LOCK_EN
                // Quota and competing requests are ignored until hlock drops.
                ARB_LOCKED: begin
                    lock_d = owner_lock;
                    if (!owner_lock) begin
                        state_d = ARB_ACTIVE;
                        take    = rearb;
                    end
                end
`endif
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
            if (take) begin
                beat_d = '0;
                if (|pick_req) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ARB_ACTIVE;
                end else begin
                    grant_d = DEF_GNT;
                    owner_d = DEF_IDX;
                    state_d = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= DEF_GNT;
            owner_q   <= DEF_IDX;
            last_q    <= DEF_IDX;
            beat_q    <= '0;
            hmaster_q <= DEF_IDX;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            hmaster_q <= hmaster_d;
        end
    end

`ifdef AHB_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
    assign hmastlock = lock_q;
`else
    assign hmastlock = 1'b0;
`endif

    assign hgrant  = grant_q;
    assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter (NUM_MASTERS=4, DEFAULT_MASTER=0, QUOTA=2).
// Lock scenario runs only when AHB_ARB_LOCK_EN is defined.
module tb_ahb_rr_arbiter;
    import ahb_pkg::*;

    logic       clk;
    logic       rstn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .QUOTA          (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .hbusreq   (hbusreq),
`ifdef AHB_ARB_LOCK_EN
        .hlock     (hlock),
`endif
        .htrans    (htrans),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] trans;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] mst;
        logic       lck;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] gnt;
        logic [1:0] mst;
        logic       lck;
    } exp_t;

    vec_t vecs[28];
    exp_t sb[$];

    function automatic vec_t mk(logic [3:0] req, logic [1:0] trans, logic rdy,
                                logic [3:0] gnt, logic [1:0] mst);
        vec_t v;
        v.req = req; v.trans = trans; v.rdy = rdy;
        v.gnt = gnt; v.mst = mst; v.lck = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic compare_out(input exp_t e);
        chk("hgrant", e.id, 32'(hgrant), 32'(e.gnt));
        chk("hmaster", e.id, 32'(hmaster), 32'(e.mst));
        chk("hmastlock", e.id, 32'(hmastlock), 32'(e.lck));
        chk("onehot", e.id, 32'($onehot(hgrant)), 32'd1);
        $display("step %0d req=%b trans=%0d rdy=%0b -> hgrant=%b hmaster=%0d hmastlock=%0b",
                 e.id, hbusreq, htrans, hready, hgrant, hmaster, hmastlock);
    endtask

    // Drive one cycle of inputs, queue the expectation, sample 1 ns after the edge.
    task automatic step(input int id, input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] trans, input logic rdy,
                        input logic [3:0] gnt, input logic [1:0] mst, input logic lck);
        exp_t e;
        hbusreq = req;
        hlock   = lk;
        htrans  = trans;
        hready  = rdy;
        e.id = id; e.gnt = gnt; e.mst = mst; e.lck = lck;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(sb.pop_front());
    endtask

    initial begin
        exp_t e;
        // Round robin with quota 2, then stall, handover, saturation, idle return, htrans types.
        vecs[0]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0);
        vecs[1]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1);
        vecs[2]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1);
        vecs[3]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd2);
        vecs[4]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd2);
        vecs[5]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3);
        vecs[6]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd3);
        vecs[7]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0);
        vecs[8]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0);
        vecs[9]  = mk(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1);
        vecs[10] = mk(4'b1101, HTRANS_NONSEQ, 1'b0, 4'b0010, 2'd1);
        vecs[11] = mk(4'b1101, HTRANS_NONSEQ, 1'b0, 4'b0010, 2'd1);
        vecs[12] = mk(4'b1101, HTRANS_NONSEQ, 1'b0, 4'b0010, 2'd1);
        vecs[13] = mk(4'b1101, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1);
        vecs[14] = mk(4'b0100, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd2);
        vecs[15] = mk(4'b1000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd2);
        vecs[16] = mk(4'b1000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3);
        vecs[17] = mk(4'b1000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3);
        vecs[18] = mk(4'b1000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3);
        vecs[19] = mk(4'b1001, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd3);
        vecs[20] = mk(4'b0010, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0);
        vecs[21] = mk(4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd1);
        vecs[22] = mk(4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0);
        vecs[23] = mk(4'b0001, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0);
        vecs[24] = mk(4'b0011, HTRANS_IDLE,   1'b1, 4'b0001, 2'd0);
        vecs[25] = mk(4'b0011, HTRANS_BUSY,   1'b1, 4'b0001, 2'd0);
        vecs[26] = mk(4'b0011, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0);
        vecs[27] = mk(4'b0011, HTRANS_SEQ,    1'b1, 4'b0010, 2'd0);

        // Reset with every master requesting.
        rstn    = 1'b0;
        hbusreq = 4'b1111;
        hlock   = 4'b0000;
        htrans  = HTRANS_NONSEQ;
        hready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e.id = 900; e.gnt = 4'b0001; e.mst = 2'd0; e.lck = 1'b0;
        compare_out(e);
        rstn = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(i, vecs[i].req, 4'b0000, vecs[i].trans, vecs[i].rdy,
                 vecs[i].gnt, vecs[i].mst, vecs[i].lck);
        end

        // Asynchronous reset mid-transfer: outputs return to default without a clock edge.
        hbusreq = 4'b1111;
        #1;
        rstn = 1'b0;
        #1;
        e.id = 901; e.gnt = 4'b0001; e.mst = 2'd0; e.lck = 1'b0;
        compare_out(e);
        @(posedge clk);
        #1;
        e.id = 902;
        compare_out(e);
        rstn = 1'b1;
        // First search after reset starts at master 1, not after the pre-reset owner.
        step(903, 4'b1111, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0);

`ifdef AHB_ARB_LOCK_EN
        // Master 1 locks while master 0 waits; quota is ignored until hlock falls.
        step(1000, 4'b0011, 4'b0010, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1001 + i, 4'b0011, 4'b0010, HTRANS_SEQ, 1'b1, 4'b0010, 2'd1, 1'b1);
        end
        step(1021, 4'b0011, 4'b0010, HTRANS_SEQ, 1'b0, 4'b0010, 2'd1, 1'b1);
        step(1022, 4'b0011, 4'b0000, HTRANS_SEQ, 1'b1, 4'b0001, 2'd1, 1'b0);
        step(1023, 4'b0001, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0);
`endif

        chk("scoreboard_empty", 999, 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
